// File: rtl/idma_req_splitter.sv
// idma_req_splitter
//
// Cuts one DMA transfer request (up to 65535 bytes) into chunks that the
// downstream DMA engine can run as a single burst. A chunk never crosses a
// MAX_BYTES-aligned external boundary and never runs past the MAX_BYTES
// window measured from the local word offset. Each chunk goes out as a
// 3-word command stream. Engine status words are collected, and a single
// completion reports the total OKAY bytes and a sticky error flag.
//
// Parameters
//   MAX_BYTES        chunk ceiling, power of two, 4..64
//   MAX_OUTSTANDING  commands issued but not yet answered, 1..15
//
// Build option
//   IDMA_SPLIT_ERR_ABORT_EN  when defined, the first non-OKAY status stops
//                            issuing new chunks (a stream already past CMD0
//                            completes), drains outstanding, then reports.
//
// Ports
//   aclk, aresetn                clock, asynchronous active-low reset
//   req_*                        request handshake and fields
//   cmd_m_tdata/tvalid/tlast/tready   command stream (3 words per chunk)
//   stat_s_tdata/tvalid/tlast/tready  status stream ([29:28] resp, [27:16] bytes)
//   done_valid/ready/error/bytes completion handshake
//   dbg_state_o                  current FSM state (debug)
//
// Handshake rule for every valid/ready pair: a transfer happens on a rising
// clock edge where valid and ready are both high; once valid is raised, it
// and its data hold steady until that transfer.
//
// All outputs are registered: the output process computes each output's
// next value from the next state, and a register stage drives the port.

module idma_req_splitter #(
  parameter int MAX_BYTES       = 64,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_dir,
  input  logic [15:0] req_local_addr,
  input  logic [63:0] req_ext_addr,
  input  logic [15:0] req_bytes,
  output logic [31:0] cmd_m_tdata,
  output logic        cmd_m_tvalid,
  output logic        cmd_m_tlast,
  input  logic        cmd_m_tready,
  input  logic [31:0] stat_s_tdata,
  input  logic        stat_s_tvalid,
  input  logic        stat_s_tlast,
  output logic        stat_s_tready,
  output logic        done_valid,
  input  logic        done_ready,
  output logic        done_error,
  output logic [15:0] done_bytes,
  output logic [2:0]  dbg_state_o
);

  localparam int          LOG_MAX = $clog2(MAX_BYTES);
  localparam logic [15:0] MAX_B   = 16'(MAX_BYTES);
  localparam logic [3:0]  MAX_O   = 4'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_CMD0 = 3'd2,
    S_CMD1 = 3'd3,
    S_CMD2 = 3'd4,
    S_WAIT = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t state_q, state_d;

  // Request / progress registers
  logic        dir_q,   dir_d;
  logic [15:0] local_q, local_d;
  logic [63:0] ext_q,   ext_d;
  logic [15:0] rem_q,   rem_d;
  logic [15:0] chunk_q, chunk_d;
  logic [3:0]  out_q,   out_d;
  logic        err_q,   err_d;
  logic [15:0] sum_q,   sum_d;

  // Output next values
  logic        req_ready_d;
  logic [31:0] cmd_m_tdata_d;
  logic        cmd_m_tvalid_d;
  logic        cmd_m_tlast_d;
  logic        stat_s_tready_d;
  logic        done_valid_d;
  logic        done_error_d;
  logic [15:0] done_bytes_d;

  logic        req_hs, cmd_hs, cmd2_hs, stat_hs, abort_hit;
  logic [1:0]  stat_resp;
  logic [11:0] stat_bytes;
  logic [15:0] ext_off, room_ext, room_loc, calc_chunk;

  // tlast and the unused status bits carry nothing this block needs.
  logic unused_stat;
  assign unused_stat = ^{stat_s_tlast, stat_s_tdata[31:30], stat_s_tdata[15:0]};

  assign req_hs     = req_valid & req_ready & (state_q == S_IDLE);
  assign cmd_hs     = cmd_m_tvalid & cmd_m_tready;
  assign cmd2_hs    = cmd_hs & (state_q == S_CMD2);
  assign stat_hs    = stat_s_tvalid & stat_s_tready;
  assign stat_resp  = stat_s_tdata[29:28];
  assign stat_bytes = stat_s_tdata[27:16];

`ifdef IDMA_SPLIT_ERR_ABORT_EN
  assign abort_hit = stat_hs & (stat_resp != 2'b00);
`else
  assign abort_hit = 1'b0;
`endif

  // Chunk size: smallest of the remaining bytes, the room left before the
  // next aligned external boundary, and the room from the local word offset.
  always_comb begin
    ext_off    = 16'(ext_q[LOG_MAX-1:0]);
    room_ext   = MAX_B - ext_off;
    room_loc   = MAX_B - {14'b0, local_q[1:0]};
    calc_chunk = rem_q;
    if (room_ext < calc_chunk) calc_chunk = room_ext;
    if (room_loc < calc_chunk) calc_chunk = room_loc;
  end

  // Datapath next-state
  always_comb begin
    dir_d   = dir_q;
    local_d = local_q;
    ext_d   = ext_q;
    rem_d   = rem_q;
    chunk_d = chunk_q;
    out_d   = out_q;
    err_d   = err_q;
    sum_d   = sum_q;

    if (req_hs) begin
      dir_d   = req_dir;
      local_d = req_local_addr;
      ext_d   = req_ext_addr;
      rem_d   = req_bytes;
      err_d   = 1'b0;
      sum_d   = '0;
      out_d   = '0;
    end

    if (state_q == S_CALC) chunk_d = calc_chunk;

    if (cmd2_hs) begin
      local_d = local_q + chunk_q;
      ext_d   = ext_q + {48'b0, chunk_q};
      // rem can already be zero after an abort; never wrap below zero.
      rem_d   = (rem_q >= chunk_q) ? (rem_q - chunk_q) : 16'd0;
    end

    // A status in the same cycle as a CMD2 handshake cancels out.
    case ({cmd2_hs, stat_hs})
      2'b10:   out_d = out_q + 4'd1;
      2'b01:   out_d = out_q - 4'd1;
      default: out_d = out_q;
    endcase

    if (stat_hs) begin
      if (stat_resp != 2'b00) err_d = 1'b1;
      else                    sum_d = sum_q + 16'(stat_bytes);
    end

    if (abort_hit) rem_d = '0;
  end

  // FSM: state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_hs) state_d = (req_bytes == 16'd0) ? S_DONE : S_CALC;
      S_CALC: state_d = abort_hit ? S_WAIT : S_CMD0;
      S_CMD0: if (cmd_hs) state_d = S_CMD1;
      S_CMD1: if (cmd_hs) state_d = S_CMD2;
      S_CMD2: if (cmd_hs) state_d = ((rem_d == 16'd0) || (out_d == MAX_O)) ? S_WAIT : S_CALC;
      S_WAIT: begin
        // Issue again as soon as a status frees a slot; finish only once
        // the registered count shows every command answered.
        if ((rem_d != 16'd0) && (out_d < MAX_O))      state_d = S_CALC;
        else if ((rem_q == 16'd0) && (out_q == 4'd0)) state_d = S_DONE;
      end
      S_DONE: if (done_valid && done_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: output logic (next values of the registered outputs)
  always_comb begin
    req_ready_d     = (state_d == S_IDLE);
    cmd_m_tvalid_d  = (state_d == S_CMD0) || (state_d == S_CMD1) || (state_d == S_CMD2);
    cmd_m_tlast_d   = (state_d == S_CMD2);
    stat_s_tready_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_valid_d    = (state_d == S_DONE);
    done_error_d    = (state_d == S_DONE) ? err_d : 1'b0;
    done_bytes_d    = (state_d == S_DONE) ? sum_d : 16'd0;
    case (state_d)
      S_CMD0:  cmd_m_tdata_d = {dir_d, 3'b000, chunk_d[11:0], local_d};
      S_CMD1:  cmd_m_tdata_d = ext_d[31:0];
      S_CMD2:  cmd_m_tdata_d = ext_d[63:32];
      default: cmd_m_tdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      dir_q   <= 1'b0;
      local_q <= '0;
      ext_q   <= '0;
      rem_q   <= '0;
      chunk_q <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
      sum_q   <= '0;
    end else begin
      dir_q   <= dir_d;
      local_q <= local_d;
      ext_q   <= ext_d;
      rem_q   <= rem_d;
      chunk_q <= chunk_d;
      out_q   <= out_d;
      err_q   <= err_d;
      sum_q   <= sum_d;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      req_ready     <= 1'b0;
      cmd_m_tdata   <= '0;
      cmd_m_tvalid  <= 1'b0;
      cmd_m_tlast   <= 1'b0;
      stat_s_tready <= 1'b0;
      done_valid    <= 1'b0;
      done_error    <= 1'b0;
      done_bytes    <= '0;
    end else begin
      req_ready     <= req_ready_d;
      cmd_m_tdata   <= cmd_m_tdata_d;
      cmd_m_tvalid  <= cmd_m_tvalid_d;
      cmd_m_tlast   <= cmd_m_tlast_d;
      stat_s_tready <= stat_s_tready_d;
      done_valid    <= done_valid_d;
      done_error    <= done_error_d;
      done_bytes    <= done_bytes_d;
    end
  end

  assign dbg_state_o = state_q;

endmodule
